// File: rtl/branch_resolve_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_pkg
// Shared definitions for the EX-stage branch resolution controller:
//   - redirect FSM state encoding (BR_IDLE / BR_REDIRECT)
//   - BHT counter reset value and a saturating 2-bit counter update helper
//   - common signal constants (RstnEnable, ZeroSignal, OneSignal, RegDataBus)
// -----------------------------------------------------------------------------
package branch_resolve_pkg;

  // Width of architectural register / PC data.
  localparam int RegDataBus = 32;

  // Level of rst_i that holds the block in reset.
  localparam logic RstnEnable = 1'b0;

  localparam logic ZeroSignal = 1'b0;
  localparam logic OneSignal  = 1'b1;

  // Redirect FSM. REDIRECT is also the stall condition.
  typedef enum logic [0:0] {
    BR_IDLE     = 1'b0,
    BR_REDIRECT = 1'b1
  } br_state_e;

  // Every BHT counter starts weakly not-taken.
  localparam logic [1:0] BHT_CNT_RST = 2'b01;

  // Two-bit saturating counter step: up on taken, down on not-taken.
  function automatic logic [1:0] bht_sat_update(input logic [1:0] cnt,
                                                input logic       taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != 2'b11) res = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_bht.sv
// -----------------------------------------------------------------------------
// branch_bht
// Array of BHT_ENTRIES 2-bit saturating counters with one combinational read
// port and one clocked update port. A read of the index being updated in the
// same cycle returns the pre-update value (the write lands on the clock edge).
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset (all counters 01)
//   rd_idx_i            read index
//   rd_taken_o          MSB of the counter at rd_idx_i
//   upd_en_i            apply an update this cycle
//   upd_idx_i           update index
//   upd_taken_i         1 = increment, 0 = decrement
// -----------------------------------------------------------------------------
module branch_bht
  import branch_resolve_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] cnt_q [BHT_ENTRIES];
  logic [1:0] cnt_d [BHT_ENTRIES];

  always_comb begin
    for (int i = 0; i < BHT_ENTRIES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (upd_en_i && (upd_idx_i == IDX_W'(i))) begin
        cnt_d[i] = bht_sat_update(cnt_q[i], upd_taken_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RstnEnable) begin
      for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= BHT_CNT_RST;
    end else begin
      for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rd_taken_o = cnt_q[rd_idx_i][1];

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// EX-stage branch resolution and PC-redirect controller (downstream of bcu).
// Resolves the EX control-flow instruction, compares the architectural next PC
// with the fetch-time prediction, and on a mispredict flushes IF/ID and raises
// a redirect to fetch.
//
// Optional feature: define BRANCH_RESOLVE_BHT_EN to build the branch history
// table (branch_bht) that drives if_pred_taken_o; otherwise it is tied to 0.
//
// Redirect handshake: redirect_valid_o rises with a new redirect_pc_o and both
// stay stable until a cycle in which redirect_ready_i is high; that cycle
// completes the transfer and redirect_valid_o drops on the following edge.
// While the redirect is pending the EX instruction is ignored and stall_o=1.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   ex_valid_i, ex_is_*_i         EX instruction valid / one-hot type
//   ex_pc_i, ex_imm_i, ex_rs1_i   operands for target computation
//   branch_enable_i               conditional branch outcome from bcu
//   ex_pred_taken_i/target_i      prediction carried from fetch
//   if_pc_i, if_pred_taken_o      BHT lookup for the fetch PC
//   redirect_valid_o/pc_o/ready_i redirect handshake to fetch
//   flush_o                       one-cycle IF/ID kill
//   stall_o                       hold EX and earlier stages
//   mispredict_cnt_o              saturating mispredict count
//   dbg_state_o                   current redirect FSM state
// -----------------------------------------------------------------------------
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int BHT_ENTRIES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_is_branch_i,
  input  logic                  ex_is_jal_i,
  input  logic                  ex_is_jalr_i,
  input  logic [RegDataBus-1:0] ex_pc_i,
  input  logic [RegDataBus-1:0] ex_imm_i,
  input  logic [RegDataBus-1:0] ex_rs1_i,
  input  logic                  branch_enable_i,
  input  logic                  ex_pred_taken_i,
  input  logic [RegDataBus-1:0] ex_pred_target_i,
  input  logic [RegDataBus-1:0] if_pc_i,
  output logic                  if_pred_taken_o,
  output logic                  redirect_valid_o,
  output logic [RegDataBus-1:0] redirect_pc_o,
  input  logic                  redirect_ready_i,
  output logic                  flush_o,
  output logic                  stall_o,
  output logic [RegDataBus-1:0] mispredict_cnt_o,
  output br_state_e             dbg_state_o
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

  // ---------------------------------------------------------------------------
  // Combinational resolution
  // ---------------------------------------------------------------------------
  logic                  cf_valid;
  logic                  actual_taken;
  logic [RegDataBus-1:0] jalr_sum;
  logic [RegDataBus-1:0] target;
  logic [RegDataBus-1:0] seq_pc;
  logic [RegDataBus-1:0] next_pc;
  logic                  mispredict;

  assign cf_valid     = ex_valid_i & (ex_is_branch_i | ex_is_jal_i | ex_is_jalr_i);
  assign actual_taken = ex_is_jal_i | ex_is_jalr_i | (ex_is_branch_i & branch_enable_i);

  // JALR clears bit 0 of the sum; all adds wrap at 32 bits.
  assign jalr_sum = ex_rs1_i + ex_imm_i;
  assign target   = ex_is_jalr_i ? {jalr_sum[RegDataBus-1:1], ZeroSignal}
                                 : (ex_pc_i + ex_imm_i);
  assign seq_pc   = ex_pc_i + 32'd4;
  assign next_pc  = actual_taken ? target : seq_pc;

  // A taken prediction with the wrong target is a mispredict; a not-taken
  // prediction ignores ex_pred_target_i entirely.
  assign mispredict = cf_valid &
                      ((actual_taken != ex_pred_taken_i) |
                       (actual_taken & (target != ex_pred_target_i)));

  // ---------------------------------------------------------------------------
  // Redirect FSM and registered outputs
  // ---------------------------------------------------------------------------
  br_state_e             state_q, state_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [RegDataBus-1:0] redirect_pc_q, redirect_pc_d;
  logic                  flush_q, flush_d;
  logic [RegDataBus-1:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = ZeroSignal;   // flush is a single-cycle pulse
    mispredict_cnt_d = mispredict_cnt_q;
    case (state_q)
      BR_IDLE: begin
        if (mispredict) begin
          state_d          = BR_REDIRECT;
          redirect_valid_d = OneSignal;
          redirect_pc_d    = next_pc;
          flush_d          = OneSignal;
          if (mispredict_cnt_q != 32'hFFFF_FFFF) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
          end
        end
      end
      BR_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d          = BR_IDLE;
          redirect_valid_d = ZeroSignal;
        end
      end
      default: begin
        state_d          = BR_IDLE;
        redirect_valid_d = ZeroSignal;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RstnEnable) begin
      state_q          <= BR_IDLE;
      redirect_valid_q <= ZeroSignal;
      redirect_pc_q    <= '0;
      flush_q          <= ZeroSignal;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = flush_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
  assign stall_o          = (state_q == BR_REDIRECT);
  assign dbg_state_o      = state_q;

  // ---------------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------------
  logic [BHT_IDX_W-1:0] bht_rd_idx;
  logic [BHT_IDX_W-1:0] bht_upd_idx;

  assign bht_rd_idx  = if_pc_i[BHT_IDX_W+1:2];
  assign bht_upd_idx = ex_pc_i[BHT_IDX_W+1:2];

`ifdef BRANCH_RESOLVE_BHT_EN
  // Train only on conditional branches seen while the FSM is accepting work.
  logic bht_upd_en;
  logic unused_if_pc;

  assign bht_upd_en   = (state_q == BR_IDLE) & ex_valid_i & ex_is_branch_i;
  assign unused_if_pc = ^{if_pc_i[RegDataBus-1:BHT_IDX_W+2], if_pc_i[1:0]};

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .IDX_W       (BHT_IDX_W)
  ) u_bht (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_idx_i    (bht_rd_idx),
    .rd_taken_o  (if_pred_taken_o),
    .upd_en_i    (bht_upd_en),
    .upd_idx_i   (bht_upd_idx),
    .upd_taken_i (branch_enable_i)
  );
`else
  logic unused_bht;

  assign unused_bht      = ^{if_pc_i, bht_rd_idx, bht_upd_idx};
  assign if_pred_taken_o = ZeroSignal;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
// Directed steps followed by randomized traffic for branch_resolve, compared
// against a behavioural model (busy flag, pending PC, count, counter array).
// -----------------------------------------------------------------------------
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int BHT_ENTRIES = 16;
`ifdef BRANCH_RESOLVE_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_i;
  logic rst_i;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic        ex_valid_i, ex_is_branch_i, ex_is_jal_i, ex_is_jalr_i;
  logic [31:0] ex_pc_i, ex_imm_i, ex_rs1_i;
  logic        branch_enable_i, ex_pred_taken_i;
  logic [31:0] ex_pred_target_i, if_pc_i;
  logic        if_pred_taken_o, redirect_valid_o, redirect_ready_i;
  logic [31:0] redirect_pc_o;
  logic        flush_o, stall_o;
  logic [31:0] mispredict_cnt_o;
  br_state_e   dbg_state;

  branch_resolve #(.BHT_ENTRIES(BHT_ENTRIES)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ex_valid_i       (ex_valid_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_is_jal_i      (ex_is_jal_i),
    .ex_is_jalr_i     (ex_is_jalr_i),
    .ex_pc_i          (ex_pc_i),
    .ex_imm_i         (ex_imm_i),
    .ex_rs1_i         (ex_rs1_i),
    .branch_enable_i  (branch_enable_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .if_pc_i          (if_pc_i),
    .if_pred_taken_o  (if_pred_taken_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .flush_o          (flush_o),
    .stall_o          (stall_o),
    .mispredict_cnt_o (mispredict_cnt_o),
    .dbg_state_o      (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model and check bookkeeping
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          m_busy;
  bit          m_flush;
  logic [31:0] m_rpc;
  logic [31:0] m_cnt;
  int          m_bht [BHT_ENTRIES];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_flush = 0;
    m_rpc   = 32'h0;
    m_cnt   = 32'h0;
    for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;
  endtask

  function automatic int bht_index(input logic [31:0] pc);
    return int'((pc >> 2) % BHT_ENTRIES);
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
    if (!BHT_ON) return 1'b0;
    return (m_bht[bht_index(pc)] >= 2);
  endfunction

  function automatic logic [31:0] target_of(input int typ, input logic [31:0] pc,
                                            input logic [31:0] imm, input logic [31:0] rs1);
    logic [31:0] t;
    if (typ == 2) t = (rs1 + imm) & 32'hFFFF_FFFE;
    else          t = pc + imm;
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic clear_ex();
    ex_valid_i       = 0;
    ex_is_branch_i   = 0;
    ex_is_jal_i      = 0;
    ex_is_jalr_i     = 0;
    ex_pc_i          = 32'h0;
    ex_imm_i         = 32'h0;
    ex_rs1_i         = 32'h0;
    branch_enable_i  = 0;
    ex_pred_taken_i  = 0;
    ex_pred_target_i = 32'h0;
  endtask

  // typ: 0 branch, 1 JAL, 2 JALR, 3 valid but not control flow
  task automatic set_ex(input int typ, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic en, input logic pt,
                        input logic [31:0] ptgt);
    ex_valid_i       = 1;
    ex_is_branch_i   = (typ == 0);
    ex_is_jal_i      = (typ == 1);
    ex_is_jalr_i     = (typ == 2);
    ex_pc_i          = pc;
    ex_imm_i         = imm;
    ex_rs1_i         = rs1;
    branch_enable_i  = en;
    ex_pred_taken_i  = pt;
    ex_pred_target_i = ptgt;
  endtask

  // One clock: check the combinational lookup, advance the model with the
  // inputs present at the edge, then check the registered outputs.
  task automatic step();
    bit          taken, mis;
    logic [31:0] tgt, nxt;
    int          idx;
    #1;
    check("if_pred_taken", {31'b0, if_pred_taken_o}, {31'b0, model_pred(if_pc_i)});
    if (!m_busy) begin
      m_flush = 0;
      if (ex_valid_i && (ex_is_branch_i || ex_is_jal_i || ex_is_jalr_i)) begin
        taken = ex_is_jal_i || ex_is_jalr_i || (ex_is_branch_i && branch_enable_i);
        tgt   = ex_is_jalr_i ? ((ex_rs1_i + ex_imm_i) & 32'hFFFF_FFFE) : (ex_pc_i + ex_imm_i);
        nxt   = taken ? tgt : (ex_pc_i + 32'd4);
        mis   = (taken != ex_pred_taken_i) || (taken && (tgt != ex_pred_target_i));
        if (mis) begin
          m_busy  = 1;
          m_flush = 1;
          m_rpc   = nxt;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        if (ex_is_branch_i && BHT_ON) begin
          idx = bht_index(ex_pc_i);
          if (taken && m_bht[idx] < 3)       m_bht[idx]++;
          else if (!taken && m_bht[idx] > 0) m_bht[idx]--;
        end
      end
    end else begin
      m_flush = 0;
      if (redirect_ready_i) m_busy = 0;
    end
    @(posedge clk_i);
    #1;
    check("redirect_valid", {31'b0, redirect_valid_o}, {31'b0, m_busy});
    check("flush", {31'b0, flush_o}, {31'b0, m_flush});
    check("stall", {31'b0, stall_o}, {31'b0, m_busy});
    check("state", {31'b0, dbg_state == BR_REDIRECT}, {31'b0, m_busy});
    check("mispredict_cnt", mispredict_cnt_o, m_cnt);
    if (m_busy) check("redirect_pc", redirect_pc_o, m_rpc);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int          stall_cycles;
  int          flush_cycles;
  int          typ;
  logic [31:0] pc, imm, rs1, tgt;

  initial begin
    rst_i            = 0;
    redirect_ready_i = 0;
    if_pc_i          = 32'h0;
    clear_ex();
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_valid", {31'b0, redirect_valid_o}, 32'd0);
    check("reset_flush", {31'b0, flush_o}, 32'd0);
    check("reset_stall", {31'b0, stall_o}, 32'd0);
    check("reset_pc", redirect_pc_o, 32'h0);
    check("reset_cnt", mispredict_cnt_o, 32'h0);
    check("reset_pred", {31'b0, if_pred_taken_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1;
    @(posedge clk_i);
    #1;

    // Correctly predicted not-taken BEQ.
    set_ex(0, 32'h100, 32'h20, 32'h0, 0, 0, 32'h0);
    redirect_ready_i = 1;
    step();
    check("beq_no_flush", {31'b0, flush_o}, 32'd0);
    check("beq_cnt", mispredict_cnt_o, 32'd0);
    clear_ex();
    step();

    // BNE mispredict with redirect_ready_i low for three cycles; a mispredicting
    // JAL sits in EX meanwhile and must be ignored.
    set_ex(0, 32'h200, 32'h40, 32'h0, 1, 0, 32'h0);
    redirect_ready_i = 0;
    step();
    check("bne_pc", redirect_pc_o, 32'h240);
    check("bne_flush", {31'b0, flush_o}, 32'd1);
    stall_cycles = stall_o ? 1 : 0;
    flush_cycles = flush_o ? 1 : 0;
    set_ex(1, 32'h300, 32'h8, 32'h0, 0, 0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      redirect_ready_i = (k >= 3);
      step();
      if (stall_o) stall_cycles++;
      if (flush_o) flush_cycles++;
      if (!stall_o) break;
    end
    clear_ex();
    check("bne_stall_cycles", stall_cycles, 32'd4);
    check("bne_flush_cycles", flush_cycles, 32'd1);
    check("bne_cnt", mispredict_cnt_o, 32'd1);

    // JALR: (0x1003 + 4) & ~1 = 0x1006, predicted 0x1000.
    redirect_ready_i = 1;
    set_ex(2, 32'h800, 32'h4, 32'h1003, 0, 1, 32'h1000);
    step();
    check("jalr_pc", redirect_pc_o, 32'h1006);
    clear_ex();
    step();

    // Not-taken branch at the top of the address space wraps to 0.
    set_ex(0, 32'hFFFF_FFFC, 32'h10, 32'h0, 0, 1, 32'h0000_000C);
    step();
    check("wrap_pc", redirect_pc_o, 32'h0);
    clear_ex();
    step();

`ifdef BRANCH_RESOLVE_BHT_EN
    // Three correctly predicted taken branches at 0x40, looked up from fetch
    // in the same cycle: old value seen each time.
    if_pc_i = 32'h40;
    for (int k = 0; k < 3; k++) begin
      set_ex(0, 32'h40, 32'h10, 32'h0, 1, 1, 32'h50);
      #1;
      check("bht_seq", {31'b0, if_pred_taken_o}, (k == 0) ? 32'd0 : 32'd1);
      step();
    end
    set_ex(0, 32'h40, 32'h10, 32'h0, 0, 0, 32'h0);
    step();
    clear_ex();
    #1;
    check("bht_after_nt", {31'b0, if_pred_taken_o}, 32'd1);
    step();
`endif

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      typ = $urandom_range(0, 3);
      pc  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                        : (32'($urandom_range(0, 63)) << 2);
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      rs1 = $urandom;
      tgt = target_of(typ, pc, imm, rs1);
      set_ex(typ, pc, imm, rs1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) != 0) ? tgt : $urandom);
      ex_valid_i       = ($urandom_range(0, 4) != 0);
      if_pc_i          = 32'($urandom_range(0, 63)) << 2;
      redirect_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    clear_ex();
    redirect_ready_i = 1;
    step();
    step();

    // Asynchronous reset while a redirect is pending.
    redirect_ready_i = 0;
    set_ex(1, 32'h500, 32'h20, 32'h0, 0, 0, 32'h0);
    step();
    clear_ex();
    check("pre_rst_stall", {31'b0, stall_o}, 32'd1);
    #2;
    rst_i = 0;
    #1;
    check("arst_valid", {31'b0, redirect_valid_o}, 32'd0);
    check("arst_stall", {31'b0, stall_o}, 32'd0);
    check("arst_flush", {31'b0, flush_o}, 32'd0);
    check("arst_cnt", mispredict_cnt_o, 32'd0);
    check("arst_pc", redirect_pc_o, 32'h0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Branch resolution and PC-redirect controller in the EX stage, directly downstream of `bcu`. It consumes `bcu`'s `branch_enable_o` together with the EX-stage control-flow instruction and computes the architecturally correct next PC. It compares that PC against the prediction carried down the pipe and, on a mispredict, flushes IF/ID and drives a redirect handshake to fetch. An optional branch history table supplies fetch-time predictions.

## Interface
Parameters:
- `BHT_ENTRIES`, default 16: number of 2-bit counters; power of two, minimum 2.

Ports:
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `ex_valid_i`  in  1  EX holds a valid instruction this cycle.
- `ex_is_branch_i`  in  1  conditional branch (BEQ..BGEU).
- `ex_is_jal_i`  in  1  JAL.
- `ex_is_jalr_i`  in  1  JALR.
- `ex_pc_i`  in  32  PC of the EX instruction.
- `ex_imm_i`  in  32  sign-extended immediate.
- `ex_rs1_i`  in  32  rs1 operand, used by JALR.
- `branch_enable_i`  in  1  from `bcu.branch_enable_o`.
- `ex_pred_taken_i`  in  1  prediction made at fetch.
- `ex_pred_target_i`  in  32  predicted target.
- `if_pc_i`  in  32  fetch PC used for BHT lookup.
- `if_pred_taken_o`  out  1  BHT prediction for `if_pc_i`.
- `redirect_valid_o`  out  1  redirect request to fetch.
- `redirect_pc_o`  out  32  corrected PC.
- `redirect_ready_i`  in  1  fetch accepts the redirect.
- `flush_o`  out  1  kill IF/ID contents.
- `stall_o`  out  1  hold EX and all earlier stages.
- `mispredict_cnt_o`  out  32  saturating mispredict count.

## Operation
- A control-flow instruction is valid when `ex_valid_i` is high and one of the three type bits is set. Type bits are one-hot; behaviour with more than one set is undefined.
- `actual_taken` = `ex_is_jal_i` | `ex_is_jalr_i` | (`ex_is_branch_i` & `branch_enable_i`).
- Target:
  - JAL and branches: `ex_pc_i + ex_imm_i`.
  - JALR: `(ex_rs1_i + ex_imm_i) & ~32'h1`.
  - All additions are 32-bit and wrap modulo 2^32.
- Correct next PC is the target when taken, otherwise `ex_pc_i + 4`, also wrapping.
- Mispredict when `actual_taken != ex_pred_taken_i`, or when `actual_taken` and target != `ex_pred_target_i`.
- FSM states:
  - IDLE: on a mispredict, latch the correct next PC into `redirect_pc_o`, set `redirect_valid_o`, pulse `flush_o`, increment the counter, and go to REDIRECT.
  - REDIRECT: hold `redirect_valid_o` and `redirect_pc_o` stable, and ignore `ex_valid_i`. On `redirect_ready_i`, go to IDLE and clear `redirect_valid_o`.
- `stall_o` = (state == REDIRECT), decoded combinationally from the state register.
- `mispredict_cnt_o` saturates at 32'hFFFF_FFFF.

## Timing
- Resolution is combinational in cycle N, when the instruction is in EX. `redirect_valid_o`, `redirect_pc_o` and `flush_o` are registered and first visible in cycle N+1.
- `flush_o` is high for exactly one cycle (N+1), regardless of how long the handshake takes.
- If `redirect_ready_i` is high in N+1, the state is IDLE at N+2, giving a one-cycle redirect and one stall cycle. Each low cycle of `redirect_ready_i` adds one cycle to both.
- A new mispredict can be accepted in the first IDLE cycle after the handshake.
- Reset values: state IDLE; `redirect_valid_o`, `flush_o` and `stall_o` = 0; `redirect_pc_o` = 0; `mispredict_cnt_o` = 0; all BHT counters = 2'b01.
- Reset asserted mid-REDIRECT clears all outputs immediately, without waiting for a clock edge.

## Configuration
- `BRANCH_RESOLVE_BHT_EN` defined:
  - BHT of `BHT_ENTRIES` 2-bit saturating counters, indexed by `pc[log2(BHT_ENTRIES)+1:2]`.
  - Update on the clock edge ending any IDLE cycle where a valid conditional branch is in EX: increment when taken, decrement when not.
  - `if_pred_taken_o` = counter[1] at the `if_pc_i` index, read combinationally.
  - A read and write to the same index in the same cycle returns the old value.
- Not defined: no BHT storage; `if_pred_taken_o` is tied to 0.

## Structure
- `define.v` holds the FSM state encodings (`BR_IDLE`, `BR_REDIRECT`), the BHT counter reset value, and a new `RstnEnable` constant (1'b0). It reuses `` `RegDataBus ``, `` `ZeroSignal `` and `` `OneSignal ``.
- One sub-module, `branch_bht`, implements the counter array with a read and an update port and is instantiated only under the macro.

## Test plan
- Reset in REDIRECT with `redirect_ready_i`=0: drive `rst_i`=0 → `redirect_valid_o`, `stall_o` and `flush_o` go to 0 without a clock edge; the counter reads 0.
- Correctly predicted BEQ: pc 0x100, `branch_enable_i`=0, `ex_pred_taken_i`=0 → no redirect, no flush, count stays 0.
- BNE mispredict: pc 0x200, imm 0x40, `branch_enable_i`=1, `ex_pred_taken_i`=0, `redirect_ready_i` low for 3 cycles → `redirect_pc_o` 0x240; `flush_o` high one cycle; `stall_o` high 4 cycles; count 1.
- JALR target: rs1 0x1003, imm 0x4, predicted taken to 0x1000 → `redirect_pc_o` 0x1006.
- Wrap: not-taken branch at pc 0xFFFF_FFFC predicted taken → `redirect_pc_o` 0x0000_0000.
- BHT (macro on): three taken branches at pc 0x40 → `if_pred_taken_o` for `if_pc_i` 0x40 reads 0, 1, 1 (counter saturates at 11). One not-taken branch follows → still 1.
